activation_scheduler: RTL

//  Sequences one shared tanh activation unit (32-bit signed z in, a out) across a layer's neurons.

---
 rtl/activation_scheduler_if.sv | 32 +++
 rtl/activation_scheduler.sv | 116 +++++++++++
 2 files changed

// File: rtl/activation_scheduler_if.sv
// Bus bundle between the activation scheduler and its environment: control, z-buffer read port,
// shared tanh unit operand/result, and activation-buffer write port.
interface activation_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 32
);
    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic             start;
    logic [IW:0]      cfg_count;
    logic             pause;
    logic             busy;
    logic             done;
    logic             z_rd;
    logic [IW-1:0]    z_addr;
    logic [WIDTH-1:0] z_data;
    logic [WIDTH-1:0] act_z;
    logic [WIDTH-1:0] act_a;
    logic             a_we;
    logic [IW-1:0]    a_addr;
    logic [WIDTH-1:0] a_data;

    modport master (
        input  start, cfg_count, pause, z_data, act_a,
        output busy, done, z_rd, z_addr, act_z, a_we, a_addr, a_data
    );

    modport slave (
        output start, cfg_count, pause, z_data, act_a,
        input  busy, done, z_rd, z_addr, act_z, a_we, a_addr, a_data
    );
endinterface

// File: rtl/activation_scheduler.sv
// Sequences one shared tanh unit over a layer: reads z[i], registers it into act_z,
// and writes the unit's result to a[i] once the index/valid pipe reaches the end.
module activation_scheduler #(
    parameter int N_NEURONS   = 4,
    parameter int WIDTH       = 32,
    parameter int ACT_LATENCY = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    activation_scheduler_if.master bus
);
    localparam int IW    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int DEPTH = 2 + ACT_LATENCY;
    localparam logic [IW:0] N_MAX = (IW+1)'(N_NEURONS);
    localparam logic [IW:0] ONE   = (IW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW:0]      cnt_q, cnt_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [DEPTH-1:0] vld_q;
    logic [IW-1:0]    idx_q [DEPTH];
    logic [WIDTH-1:0] act_z_q;

    logic [IW:0]      cnt_clamp;
    logic             issue;
    logic             last_rd;

    assign cnt_clamp = (bus.cfg_count > N_MAX) ? N_MAX : bus.cfg_count;
    assign issue     = (state_q == S_ISSUE) && !bus.pause;
    assign last_rd   = ({1'b0, rd_idx_q} == (cnt_q - ONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d    = cnt_clamp;
                    rd_idx_d = '0;
                    state_d  = (cnt_clamp != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (!bus.pause) begin
                    if (last_rd) begin
                        state_d = S_DRAIN;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once only the final stage can still hold data; it writes this cycle.
                if (vld_q[DEPTH-2:0] == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            act_z_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[DEPTH-2:0], issue};
            idx_q[0] <= rd_idx_q;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                idx_q[i] <= idx_q[i-1];
            end
            if (vld_q[0]) begin
                act_z_q <= bus.z_data;
            end
        end
    end

    always_comb begin
        bus.busy   = (state_q != S_IDLE);
        bus.done   = (state_q == S_DONE);
        bus.z_rd   = issue;
        bus.z_addr = issue ? rd_idx_q : '0;
        bus.act_z  = act_z_q;
        bus.a_we   = vld_q[DEPTH-1];
        bus.a_addr = vld_q[DEPTH-1] ? idx_q[DEPTH-1] : '0;
        bus.a_data = vld_q[DEPTH-1] ? bus.act_a : '0;
    end
endmodule
